// File: rtl/div_unit_if.sv
// Request/response bundle between the register-file read side and the divider.
interface div_unit_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  start;
  logic [1:0]            op;
  logic [XLEN-1:0]       dividend;
  logic [XLEN-1:0]       divisor;
  logic [REG_ADDR_W-1:0] rd;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_reg;
  logic [XLEN-1:0]       wr_data;

  modport master (
    output start, op, dividend, divisor, rd, kill,
    input  busy, done, wr_en, wr_reg, wr_data
  );

  modport slave (
    input  start, op, dividend, divisor, rd, kill,
    output busy, done, wr_en, wr_reg, wr_data
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider: one restoring-division step per clock, results
// returned as a single-cycle register-file write strobe.
module div_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       quo_q, quo_d;   // dividend shifts out as quotient shifts in
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;

  // Operand preparation at accept time
  logic            is_signed, dvd_neg, dvs_neg, div_zero, ovf, special;
  logic [XLEN-1:0] dvd_abs, dvs_abs, special_res;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  assign is_signed   = ~bus.op[0];
  assign dvd_neg     = is_signed & bus.dividend[XLEN-1];
  assign dvs_neg     = is_signed & bus.divisor[XLEN-1];
  assign dvd_abs     = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_abs     = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  assign div_zero    = (bus.divisor == '0);
  assign ovf         = is_signed && (bus.dividend == MinInt) && (bus.divisor == '1);
  assign special     = div_zero | ovf;
  assign special_res = div_zero ? (bus.op[1] ? bus.dividend : '1)
                                : (bus.op[1] ? '0 : MinInt);

  // One restoring step; the shifted partial remainder needs one extra bit
  logic [XLEN:0]   shifted;
  logic            take;
  logic [XLEN-1:0] rem_step, quo_step, rem_sub, q_fix, r_fix, calc_res;

  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign take     = (shifted >= {1'b0, dvs_q});
  assign rem_sub  = shifted[XLEN-1:0] - dvs_q;  // exact when take: result < divisor
  assign rem_step = take ? rem_sub : shifted[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], take};
  assign q_fix    = qneg_q ? (~quo_step + 1'b1) : quo_step;
  assign r_fix    = rneg_q ? (~rem_step + 1'b1) : rem_step;
  assign calc_res = op_q[1] ? r_fix : q_fix;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    rd_d      = rd_q;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d   = bus.op;
          rd_d   = bus.rd;
          rem_d  = '0;
          cnt_d  = '0;
          quo_d  = dvd_abs;
          dvs_d  = dvs_abs;
          qneg_d = dvd_neg ^ dvs_neg;
          rneg_d = dvd_neg;
          if (special) begin
            state_d   = StDone;
            wr_reg_d  = bus.rd;
            wr_data_d = special_res;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d   = StDone;
          wr_reg_d  = rd_q;
          wr_data_d = calc_res;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Flush wins over everything, including a same-cycle start or completion
    if (bus.kill) begin
      state_d   = StIdle;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
    end

    done_d  = (state_d == StDone);
    wr_en_d = done_d && (wr_reg_d != '0);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rd_q      <= '0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      rd_q      <= rd_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_reg  = wr_reg_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  div_unit_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  div_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M semantics from plain arithmetic
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0:    return ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return ovf ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op at the earliest legal edge and wait for its done pulse.
  // cycles = 1 when done is visible right after the accept edge; -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data,
                        output logic [4:0] wreg, output logic wen, output int cycles);
    int guard;
    guard = 0;
    while (bus.busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.rd       = rd;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles    = 1;
    while (!bus.done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    data = bus.wr_data;
    wreg = bus.wr_reg;
    wen  = bus.wr_en;
    if (!bus.done) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.kill     = 1'b0;
    bus.op       = 2'd0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.rd       = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.wr_reg !== 5'd0) begin errors++; $display("FAIL reset_wr_reg got=%0d exp=0", bus.wr_reg); end
    checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [4:0] r; logic w; int c;
    run_op(2'd1, 32'd100, 32'd7, 5'd5, d, r, w, c);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_data got=%0d exp=14", d); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL divu_wr_en got=%b exp=1", w); end
    checks++; if (r !== 5'd5) begin errors++; $display("FAIL divu_wr_reg got=%0d exp=5", r); end
    checks++; if (c != 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", c); end
    // done must be a single-cycle pulse
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", bus.done); end
    run_op(2'd3, 32'd100, 32'd7, 5'd5, d, r, w, c);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_data got=%0d exp=2", d); end
  endtask

  task automatic test_signed();
    logic [31:0] d; logic [4:0] r; logic w; int c;
    run_op(2'd0, -32'sd7, 32'd2, 5'd1, d, r, w, c);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got=%h exp=fffffffd", d); end
    run_op(2'd2, -32'sd7, 32'd2, 5'd1, d, r, w, c);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg_dvd got=%h exp=ffffffff", d); end
    run_op(2'd2, 32'd7, -32'sd2, 5'd1, d, r, w, c);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL rem_neg_dvs got=%h exp=1", d); end
  endtask

  task automatic test_special();
    logic [31:0] d; logic [4:0] r; logic w; int c;
    run_op(2'd0, 32'd42, 32'd0, 5'd3, d, r, w, c);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero got=%h exp=ffffffff", d); end
    checks++; if (c != 1) begin errors++; $display("FAIL div_by_zero_lat got=%0d exp=1", c); end
    run_op(2'd3, 32'd42, 32'd0, 5'd3, d, r, w, c);
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL remu_by_zero got=%h exp=2a", d); end
    checks++; if (c != 1) begin errors++; $display("FAIL remu_by_zero_lat got=%0d exp=1", c); end
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, d, r, w, c);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got=%h exp=80000000", d); end
    checks++; if (c != 1) begin errors++; $display("FAIL div_ovf_lat got=%0d exp=1", c); end
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, d, r, w, c);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rem_ovf got=%h exp=0", d); end
    checks++; if (c != 1) begin errors++; $display("FAIL rem_ovf_lat got=%0d exp=1", c); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d; logic [4:0] r; int n_done; int guard;
    guard = 0;
    while (bus.busy && guard < 50) begin @(posedge clk); #1; guard++; end
    bus.op = 2'd1; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.rd = 5'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_done = 0; d = '0; r = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5 || k == 10) begin
        bus.op = 2'd1; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.rd = 5'd7;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin n_done++; d = bus.wr_data; r = bus.wr_reg; end
    end
    bus.start = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", n_done); end
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL busy_data got=%0d exp=14", d); end
    checks++; if (r !== 5'd5) begin errors++; $display("FAIL busy_wr_reg got=%0d exp=5", r); end
  endtask

  task automatic test_rd0();
    logic [31:0] d; logic [4:0] r; logic w; int c;
    run_op(2'd1, 32'd20, 32'd4, 5'd0, d, r, w, c);
    checks++; if (c != 33) begin errors++; $display("FAIL rd0_done got_latency=%0d exp=33", c); end
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL rd0_wr_en got=%b exp=0", w); end
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL rd0_data got=%0d exp=5", d); end
  endtask

  task automatic test_kill();
    logic [31:0] d; logic [4:0] r; logic w; int c; int n_done;
    bus.op = 2'd1; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'd3; bus.rd = 5'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL kill_busy got=%b exp=0", bus.busy); end
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL kill_no_done got=%0d exp=0", n_done); end
    run_op(2'd1, 32'd9, 32'd3, 5'd4, d, r, w, c);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL after_kill_data got=%0d exp=3", d); end
    checks++; if (c != 33) begin errors++; $display("FAIL after_kill_lat got=%0d exp=33", c); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [4:0] r; logic w; int c;
    // previous ops leave wr_reg/wr_data nonzero
    @(posedge clk); #1;
    bus.op = 2'd1; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.rd = 5'd11;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wr_reg !== 5'd0) begin errors++; $display("FAIL rstmid_wr_reg got=%0d exp=0", bus.wr_reg); end
    checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL rstmid_wr_data got=%h exp=0", bus.wr_data); end
    checks++; if (bus.done !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_strobe got=%b%b exp=00", bus.done, bus.wr_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(2'd3, 32'd1000, 32'd3, 5'd11, d, r, w, c);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL rstmid_after got=%0d exp=1", d); end
  endtask

  task automatic test_random();
    logic [31:0] d; logic [4:0] r; logic w; int c;
    logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] rd; int sel;
    int bad; int cov_op [4]; int cov_zero; int cov_ovf;
    bad = 0; cov_zero = 0; cov_ovf = 0;
    for (int i = 0; i < 4; i++) cov_op[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 99);
      if (sel < 10) b = 32'd0;
      else if (sel < 16) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 40) b = $urandom_range(1, 20);
      else if (sel < 50) b = -32'($urandom_range(1, 20));
      else b = $urandom;
      cov_op[op]++;
      if (b == 32'd0) cov_zero++;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) cov_ovf++;
      run_op(op, a, b, rd, d, r, w, c);
      checks++;
      if (d !== ref_model(op, a, b) || r !== rd || w !== (rd != 5'd0)
          || c != ref_latency(op, a, b)) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand op=%0d a=%h b=%h rd=%0d got data=%h reg=%0d wen=%b lat=%0d exp data=%h lat=%0d",
                   op, a, b, rd, d, r, w, c, ref_model(op, a, b), ref_latency(op, a, b));
        bad++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cov_op[i] == 0) begin errors++; $display("FAIL cov_op%0d got=0 exp>0", i); end
    end
    checks++; if (cov_zero == 0) begin errors++; $display("FAIL cov_zero got=0 exp>0"); end
    checks++; if (cov_ovf == 0) begin errors++; $display("FAIL cov_ovf got=0 exp>0"); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_signed();
    test_special();
    test_busy_ignore();
    test_rd0();
    test_kill();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
